// File: rtl/div_pkg.sv
// Shared types and defaults for the divider arbiter and its helpers.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned WidthDefault   = 32;
  localparam int unsigned TimeoutDefault = 80;

  // Quotient reported for a bypassed divide-by-zero.
  localparam logic [WidthDefault-1:0] DivZeroQuot = '1;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: the search starts just after ptr
// and wraps, returning a one-hot grant and its index.
module rr_picker
  import div_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IdW-1:0] idx,
  output logic           found
);

  always_comb begin
    int unsigned p;
    p     = 32'(ptr);
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (i == (p + k) % N)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = IdW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider among NREQ requesters with round-robin arbitration.
// Optional macro DIV_ZERO_BYPASS_EN answers zero-divisor requests without the divider.
module div_arbiter
  import div_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = WidthDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault,
  localparam int unsigned IdW    = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IdW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_err,
  output logic                  div_run,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  output logic                  div_clear,
  input  logic                  div_ready,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  grant;
  logic [IdW-1:0]   gnt_idx;
  logic             gnt_found;
  logic [WIDTH-1:0] sel_dvd, sel_dvs;

  rr_picker #(
    .N   (NREQ),
    .IdW (IdW)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gnt_idx),
    .found (gnt_found)
  );

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_dvd = req_dividend[i*WIDTH +: WIDTH];
        sel_dvs = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    err_d     = err_q;
    req_ready = '0;
    div_run   = 1'b0;
    div_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          // Gated so no grant is visible while reset is held.
          req_ready = reset ? grant : '0;
          id_d      = gnt_idx;
          dvd_d     = sel_dvd;
          dvs_d     = sel_dvs;
          state_d   = StIssue;
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_dvs == '0) begin
            quo_d   = {WIDTH{DivZeroQuot[0]}};
            rem_d   = sel_dvd;
            err_d   = 1'b1;
            state_d = StResp;
          end
`endif
        end
      end
      StIssue: begin
        div_run = 1'b1;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // First WAIT cycle (cnt_q == 0) ignores a ready left over from the last op.
        if (cnt_q != '0 && div_ready) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          quo_d     = '0;
          rem_d     = '0;
          err_d     = 1'b1;
          div_clear = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          ptr_d   = id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= IdW'(NREQ - 1);
      id_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid     = (state_q == StResp);
  assign rsp_id        = id_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_err       = err_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a fixed-latency divider model.
module tb_div_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 80;
  localparam int unsigned LAT     = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_err;
  logic                  div_run;
  logic [WIDTH-1:0]      div_dividend;
  logic [WIDTH-1:0]      div_divisor;
  logic                  div_clear;
  logic                  div_ready;
  logic [WIDTH-1:0]      div_quotient;
  logic [WIDTH-1:0]      div_remainder;

  logic             hang;
  logic             m_busy;
  int unsigned      m_cnt;
  logic [WIDTH-1:0] m_a, m_b;
  int               n_run = 0;
  int               n_clear = 0;
  int               n_checks = 0;
  int               n_pass = 0;

  always #5 clk = ~clk;

  div_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .div_run       (div_run),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_clear     (div_clear),
    .div_ready     (div_ready),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Divider model: ready rises LAT edges after run and stays up until the next run.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0;
      div_ready <= 1'b0; div_quotient <= '0; div_remainder <= '0;
    end else if (div_clear) begin
      m_busy <= 1'b0; div_ready <= 1'b0;
    end else if (div_run) begin
      div_ready <= 1'b0; m_busy <= !hang; m_cnt <= LAT;
      m_a <= div_dividend; m_b <= div_divisor;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        div_ready     <= 1'b1;
        m_busy        <= 1'b0;
        div_quotient  <= (m_b == 0) ? '1 : m_a / m_b;
        div_remainder <= (m_b == 0) ? m_a : m_a % m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (div_run) n_run <= n_run + 1;
    if (div_clear) n_clear <= n_clear + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Counts negedges until rsp_valid is seen (bounded).
  task automatic wait_rsp(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < budget);
    if (!rsp_valid) check("rsp_wait_bound", 0, 1);
  endtask

  // One request; lat counts negedges from the grant cycle to the first rsp_valid.
  task automatic txn(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input int budget, output int lat);
    int g;
    @(posedge clk); #1;
    req_dividend[idx*WIDTH +: WIDTH] = a;
    req_divisor[idx*WIDTH +: WIDTH]  = b;
    req_valid[idx] = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready[idx] && g < 20);
    if (!req_ready[idx]) check("grant_wait_bound", 0, 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    wait_rsp(budget, lat);
  endtask

  int unsigned rr_a[4] = '{1000, 1037, 1074, 1111};
  int unsigned rr_b[4] = '{3, 4, 5, 6};
  int unsigned rr_q[4] = '{333, 259, 214, 185};
  int unsigned rr_r[4] = '{1, 1, 4, 1};

  initial begin
    int lat, run0, clr0, exp_id, g;
    logic stable;
    reset = 1'b1; hang = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_div_run", div_run, 0);
    check("rst_div_clear", div_clear, 0);
    check("rst_quotient", rsp_quotient, 0);
    check("rst_div_divisor", div_divisor, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single request, r0 first after reset.
    run0 = n_run;
    txn(0, 100, 7, 20, lat);
    check("t1_id", rsp_id, 0);
    check("t1_q", rsp_quotient, 14);
    check("t1_r", rsp_remainder, 2);
    check("t1_err", rsp_err, 0);
    check("t1_run_pulses", n_run - run0, 1);
    check("t1_latency", lat, 6);

    // All requesting: rotation continues after last winner r0.
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*WIDTH +: WIDTH] = rr_a[i];
      req_divisor[i*WIDTH +: WIDTH]  = rr_b[i];
    end
    req_valid = '1;
    exp_id = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(30, lat);
      exp_id = (exp_id + 1) % NREQ;
      check("rr_id", rsp_id, exp_id);
      check("rr_q", rsp_quotient, rr_q[exp_id]);
      check("rr_r", rsp_remainder, rr_r[exp_id]);
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Backpressure: response held, no grant while waiting.
    rsp_ready = 1'b0;
    req_dividend[2*WIDTH +: WIDTH] = 500; req_divisor[2*WIDTH +: WIDTH] = 9;
    req_dividend[3*WIDTH +: WIDTH] = 81;  req_divisor[3*WIDTH +: WIDTH] = 4;
    req_valid = 4'b1100;
    wait_rsp(30, lat);
    check("bp_id", rsp_id, 2);
    check("bp_q", rsp_quotient, 55);
    check("bp_r", rsp_remainder, 5);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_quotient != 55 || rsp_remainder != 5 || rsp_id != 2 ||
          req_ready != 0) stable = 1'b0;
    end
    check("bp_hold_stable", stable, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    @(posedge clk); #1;
    wait_rsp(30, lat);
    check("bp_next_id", rsp_id, 3);
    check("bp_next_q", rsp_quotient, 20);
    check("bp_next_r", rsp_remainder, 1);
    @(posedge clk); #1;
    req_valid = '0;

    // Hung divider: watchdog abort, then normal operation resumes.
    hang = 1'b1;
    clr0 = n_clear;
    txn(0, 9, 3, 120, lat);
    check("to_id", rsp_id, 0);
    check("to_err", rsp_err, 1);
    check("to_q", rsp_quotient, 0);
    check("to_r", rsp_remainder, 0);
    check("to_clear_pulses", n_clear - clr0, 1);
    check("to_latency", lat, TIMEOUT + 3);
    hang = 1'b0;
    txn(1, 12, 5, 20, lat);
    check("post_to_id", rsp_id, 1);
    check("post_to_q", rsp_quotient, 2);
    check("post_to_err", rsp_err, 0);

    // Zero divisor.
    run0 = n_run;
    txn(2, 55, 0, 20, lat);
    check("dz_q", rsp_quotient, 32'hFFFF_FFFF);
    check("dz_r", rsp_remainder, 55);
`ifdef DIV_ZERO_BYPASS_EN
    check("dz_err", rsp_err, 1);
    check("dz_run_pulses", n_run - run0, 0);
`else
    check("dz_err", rsp_err, 0);
    check("dz_run_pulses", n_run - run0, 1);
`endif

    // Reset during WAIT.
    hang = 1'b1;
    @(posedge clk); #1;
    req_dividend[3*WIDTH +: WIDTH] = 7; req_divisor[3*WIDTH +: WIDTH] = 7;
    req_valid = 4'b1000;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready[3] && g < 20);
    check("mr_grant", req_ready, 4'b1000);
    repeat (5) @(negedge clk);
    check("mr_in_wait_dividend", div_dividend, 7);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_div_run", div_run, 0);
    check("mr_div_dividend", div_dividend, 0);
    req_dividend[0*WIDTH +: WIDTH] = 100; req_divisor[0*WIDTH +: WIDTH] = 7;
    req_dividend[1*WIDTH +: WIDTH] = 50;  req_divisor[1*WIDTH +: WIDTH] = 5;
    req_valid = 4'b1011;
    hang = 1'b0;
    #1;
    check("mr_req_ready_in_reset", req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_rsp(30, lat);
    check("mr_first_latency", lat, 7);
    check("mr_first_id", rsp_id, 0);
    check("mr_first_q", rsp_quotient, 14);
    check("mr_first_r", rsp_remainder, 2);
    @(posedge clk); #1;
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
